// File: rtl/buffer_2d_param.sv
// -----------------------------------------------------------------------------
// buffer_2d_param
// Line-buffer window generator for the CFA demosaic stage. It accepts one
// multi-channel pixel per enabled cycle in raster order, keeps WIN-1 previous
// lines in circular line memories and presents a WIN x WIN window with a valid
// flag, the window-centre coordinates and an end-of-frame pulse.
//
// Optional feature (macro BUFFER_2D_BAYER_PHASE_EN):
//   adds bayer_phase = {win_row[0], win_col[0]} and RB_interpolation, the
//   rounded mean of the four diagonal neighbours of the centre (channel 0).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           input pixel valid
//   sof          start of frame (qualified by en), forces pixel to (0,0)
//   d_in         input pixel, channel c at [c*PIX_W +: PIX_W]
//   buffer_data  window taps, tap (i,j) at [(i*WIN+j)*CH*PIX_W +: CH*PIX_W]
//   win_valid    buffer_data holds a complete in-image window
//   win_row      image row of the window centre
//   win_col      image column of the window centre
//   frame_done   one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module buffer_2d_param #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CH    = 3,
    parameter int unsigned WIN   = 3,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         sof,
    input  logic [CH*PIX_W-1:0]          d_in,
    output logic [WIN*WIN*CH*PIX_W-1:0]  buffer_data,
    output logic                         win_valid,
    output logic [15:0]                  win_row,
    output logic [15:0]                  win_col,
    output logic                         frame_done
`ifdef BUFFER_2D_BAYER_PHASE_EN
    ,
    output logic [1:0]                   bayer_phase,
    output logic [7:0]                   RB_interpolation
`endif
);

    localparam int unsigned PW   = CH * PIX_W;
    localparam int unsigned HALF = (WIN - 1) / 2;
    localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] ColFirst = CW'(WIN - 1);
    localparam logic [RW-1:0] RowFirst = RW'(WIN - 1);

    if ((WIN % 2) == 0 || WIN < 3 || WIN > 7 || WIN > IMG_W) begin : gen_bad_win
        $error("buffer_2d_param: WIN must be odd, 3..7 and not exceed IMG_W");
    end

    // Position counters and the position of the pixel accepted this cycle
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    always_comb begin
        cur_col = sof ? '0 : col_q;
        cur_row = sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (en) begin
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = (cur_row == RowLast) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Line k holds the line k+1 above the current one; addressed by column.
    logic [PW-1:0] line_mem [WIN-1][IMG_W];
    logic [PW-1:0] line_rd  [WIN-1];

    always_comb begin
        for (int unsigned k = 0; k < WIN - 1; k++) begin
            line_rd[k] = line_mem[k][cur_col];
        end
    end

    // No reset on the storage; the valid qualifier masks stale content.
    always_ff @(posedge clk) begin
        if (en) begin
            line_mem[0][cur_col] <= d_in;
            for (int unsigned k = 1; k < WIN - 1; k++) begin
                line_mem[k][cur_col] <= line_rd[k-1];
            end
        end
    end

    // Window shift array; row 0 is the oldest line
    logic [PW-1:0] win_q [WIN][WIN];
    logic [PW-1:0] win_d [WIN][WIN];

    always_comb begin
        win_d = win_q;
        if (en) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                for (int unsigned j = 0; j < WIN - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            for (int unsigned i = 0; i < WIN - 1; i++) begin
                win_d[i][WIN-1] = line_rd[WIN-2-i];
            end
            win_d[WIN-1][WIN-1] = d_in;
        end
    end

    logic        valid_d, valid_q;
    logic        done_d, done_q;
    logic [15:0] wrow_d, wrow_q, wcol_d, wcol_q;

    always_comb begin
        valid_d = en && (cur_row >= RowFirst) && (cur_col >= ColFirst);
        done_d  = en && (cur_row == RowLast) && (cur_col == ColLast);
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        if (en) begin
            wrow_d = 16'(cur_row) - 16'(HALF);
            wcol_d = 16'(cur_col) - 16'(HALF);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            for (int unsigned i = 0; i < WIN; i++) begin
                for (int unsigned j = 0; j < WIN; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        buffer_data = '0;
        for (int unsigned i = 0; i < WIN; i++) begin
            for (int unsigned j = 0; j < WIN; j++) begin
                buffer_data[(i*WIN+j)*PW +: PW] = win_q[i][j];
            end
        end
    end

    assign win_valid  = valid_q;
    assign win_row    = wrow_q;
    assign win_col    = wcol_q;
    assign frame_done = done_q;

`ifdef BUFFER_2D_BAYER_PHASE_EN
    logic [1:0] phase_d, phase_q;
    logic [9:0] diag_sum;
    logic [7:0] rb_d, rb_q;

    // Computed from the next window so it lines up with win_valid.
    always_comb begin
        diag_sum = 10'(win_d[HALF-1][HALF-1][PIX_W-1:0])
                 + 10'(win_d[HALF-1][HALF+1][PIX_W-1:0])
                 + 10'(win_d[HALF+1][HALF-1][PIX_W-1:0])
                 + 10'(win_d[HALF+1][HALF+1][PIX_W-1:0])
                 + 10'd2;
        phase_d  = valid_d ? {wrow_d[0], wcol_d[0]} : 2'b00;
        rb_d     = valid_d ? 8'(diag_sum >> 2) : 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            rb_q    <= '0;
        end else begin
            phase_q <= phase_d;
            rb_q    <= rb_d;
        end
    end

    assign bayer_phase      = phase_q;
    assign RB_interpolation = rb_q;
`endif

endmodule

// File: doc/buffer_2d_param.md
Name: buffer_2d_param

Overview:
- Parametrised successor of the fixed 3x3, 24-bit CFA line-buffer window generator.
- Accepts one multi-channel pixel per enabled cycle in raster order.
- Stores WIN-1 previous lines in circular line memories and presents a full WIN x WIN window with valid, position and frame-done indications.
- Feeds the CFA demosaic/interpolation stage.

Parameters:
- PIX_W, 8, bits per channel sample
- CH, 3, channels per pixel (d_in width = CH*PIX_W)
- WIN, 3, window edge size; odd, 3..7
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  input pixel valid; pixel consumed on every rising edge with en=1
- sof  in  1  start of frame; qualified by en, marks the current pixel as (row 0, col 0)
- d_in  in  CH*PIX_W  input pixel
- buffer_data  out  WIN*WIN*CH*PIX_W  window taps
- win_valid  out  1  buffer_data holds a complete in-image window
- win_row  out  16  image row of the window centre
- win_col  out  16  image column of the window centre
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst=0, async): col/row counters=0, line-memory write pointer=0, window registers=0, buffer_data=0, win_valid=0, win_row=0, win_col=0, frame_done=0. Line-memory contents need not be cleared.
- Counters: col_cnt 0..IMG_W-1 and row_cnt 0..IMG_H-1 advance only on en=1.
  - Column wraps at IMG_W-1 and increments the row.
  - At (IMG_H-1, IMG_W-1) both counters wrap to 0 and frame_done pulses on the next cycle.
- sof: en=1 with sof=1 forces the accepted pixel to (0,0) regardless of counter state; the counters then continue from (0,1). Re-sync mid-frame is legal. sof with en=0 is ignored.
- Line memories: WIN-1 RAMs of IMG_W x CH*PIX_W, addressed by col_cnt.
  - On en, line k outputs the pixel at the same column from k+1 lines above.
  - Each line is written with the pixel from the line below (the newest line is written with d_in).
  - Read-before-write at the same address in the same cycle.
- Window: WIN x WIN shift register array. On en, each row shifts one column left and the new right column is loaded from {line memories, d_in}.
  - The bottom-right tap is the current pixel.
- Packing: tap (i,j) (i=0 top/oldest row, j=0 left column) sits at bits [(i*WIN+j)*CH*PIX_W +: CH*PIX_W].
  - Within a tap, channel c sits at [c*PIX_W +: PIX_W].
- Latency: buffer_data, win_valid, win_row and win_col update 1 cycle after the accepting edge. They hold their values while en=0.
- win_valid: registered to 1 when the accepted pixel has row_cnt >= WIN-1 and col_cnt >= WIN-1, else 0.
  - Windows spanning a line wrap or a frame wrap are never flagged valid.
  - On en=0, win_valid drops to 0 (single-cycle pulses per accepted pixel).
- Centre coordinates: win_row = row_cnt-(WIN-1)/2 and win_col = col_cnt-(WIN-1)/2 of the accepted pixel. Zero-extended to 16 bits; only meaningful when win_valid=1.
- Border pixels (centre within (WIN-1)/2 of any edge) never produce a window; the downstream stage handles them.
- Async reset asserted mid-frame: all outputs return to reset values immediately. The first pixel after release is treated as (0,0).
- Parameter checks: WIN even or WIN>IMG_W must fail elaboration.

Optional Feature:
- Macro: BUFFER_2D_BAYER_PHASE_EN.
- Defined: adds output port bayer_phase (2 bits) = {win_row[0], win_col[0]}, registered with win_valid. Also adds the 8-bit output RB_interpolation.
  - RB_interpolation = rounded mean of the four diagonal neighbours of the centre (channel 0 only): (sum+2)>>2, 10-bit internal sum.
  - Both outputs are 0 on reset and when win_valid=0.
- Undefined: neither port exists and no adder logic is built.

Test Plan:
- Defaults reduced to IMG_W=8, IMG_H=6, WIN=3, CH=3. Stream one frame with en=1 continuously, sof on the first pixel, ch0=row*16+col -> first win_valid at the cycle after pixel (2,2) with win_row=1, win_col=1, tap(0,0) ch0=0x00, tap(2,2) ch0=0x22. Exactly 24 valid windows in the frame; frame_done pulses once after pixel (5,7).
- Same frame with en toggling 1,0,1,0 -> identical window sequence; outputs hold during en=0 gaps and win_valid is never asserted on an en=0 follow-on cycle.
- Inject sof at pixel 20 of the frame -> counters resync; the next win_valid appears only after 2 full lines plus 3 pixels, with win_row=1, win_col=1.
- Assert rst low at row 3, col 4 -> all outputs 0 within the same cycle. After release plus sof, the window sequence matches the first scenario.
- WIN=5, IMG_W=16 build -> first valid window centre is (2,2); buffer_data width is 600 bits; tap(4,4) equals the current pixel.
- With BUFFER_2D_BAYER_PHASE_EN defined and diagonal ch0 values 10, 11, 12, 13 -> RB_interpolation=12 and bayer_phase={row[0], col[0]} of the centre.
